uart_tx_arbiter: RTL and testbench

//  Shares the single transmit path of the parity UART (w_data/wr_uart/tx_full) among N byte-stream

---
 rtl/uart_arb_pkg.sv | 14 +
 rtl/rr_picker.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// byte width and the default packet-length and stall-timeout limits.
package uart_arb_pkg;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } arb_state_e;

   localparam int BYTE_W      = 8;
   localparam int DEF_MAX_LEN = 64;
   localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: scans the request vector starting at
// the pointer position, wrapping modulo N, and returns the first set request
// as a one-hot vector and as an index.
module rr_picker
   import uart_arb_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     pick_onehot,
   output logic [IDX_W-1:0] pick_idx,
   output logic             pick_valid
);

   // Walk the N candidates in priority order starting at ptr; first hit wins.
   always_comb begin
      logic [IDX_W-1:0] cand_s;
      cand_s      = '0;
      pick_onehot = '0;
      pick_idx    = '0;
      pick_valid  = 1'b0;
      for (int k = 0; k < N; k++) begin
         cand_s = IDX_W'((int'(ptr) + k) % N);
         if (!pick_valid && req[cand_s]) begin
            pick_valid          = 1'b1;
            pick_idx            = cand_s;
            pick_onehot[cand_s] = 1'b1;
         end else begin
            pick_valid = pick_valid;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the UART TX FIFO write port
// among N byte-stream requesters. A grant is held until the owner sends a
// byte flagged last, or MAX_LEN bytes have gone out (trunc pulse).
// Optional feature: define UART_ARB_TIMEOUT_EN to also force release after
// TIMEOUT consecutive stream cycles without a transfer (trunc pulse).
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int N       = 4,
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int CNT_W   = 7,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N-1:0]        req_valid,
   input  logic [BYTE_W*N-1:0] req_data,
   input  logic [N-1:0]        req_last,
   output logic [N-1:0]        req_ready,
   output logic [N-1:0]        grant,
   output logic                wr_uart,
   output logic [BYTE_W-1:0]   w_data,
   input  logic                tx_full,
   output logic                busy,
   output logic                trunc
);

   localparam int IDX_W = $clog2(N);

   arb_state_e         state_r;
   arb_state_e         state_next_s;
   logic [N-1:0]       grant_r;
   logic [IDX_W-1:0]   owner_r;
   logic [IDX_W-1:0]   ptr_r;
   logic [CNT_W-1:0]   count_r;
   logic               busy_r;
   logic               trunc_r;

   logic [N-1:0]       pick_onehot_s;
   logic [IDX_W-1:0]   pick_idx_s;
   logic               pick_valid_s;

   logic               owner_valid_s;
   logic               owner_last_s;
   logic [BYTE_W-1:0]  owner_data_s;
   logic               xfer_s;
   logic               hit_max_s;
   logic               release_s;
   logic               trunc_next_s;
   logic               timeout_hit_s;

   rr_picker #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_picker (
      .req         (req_valid),
      .ptr         (ptr_r),
      .pick_onehot (pick_onehot_s),
      .pick_idx    (pick_idx_s),
      .pick_valid  (pick_valid_s)
   );

   assign owner_valid_s = req_valid[owner_r];
   assign owner_last_s  = req_last[owner_r];
   assign owner_data_s  = req_data[{owner_r, 3'b000} +: BYTE_W];

   // Transfer and release conditions for the current owner.
   always_comb begin
      xfer_s       = (state_r == ST_STREAM) & owner_valid_s & ~tx_full;
      hit_max_s    = xfer_s & ((count_r + CNT_W'(1)) == CNT_W'(MAX_LEN));
      release_s    = (xfer_s & owner_last_s) | hit_max_s | timeout_hit_s;
      trunc_next_s = (hit_max_s & ~owner_last_s) | timeout_hit_s;
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);

   logic [TO_W-1:0] stall_r;

   // Count consecutive stream cycles without a transfer; any transfer or leaving STREAM clears it.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_r <= '0;
      end else if ((state_r != ST_STREAM) || xfer_s) begin
         stall_r <= '0;
      end else begin
         stall_r <= stall_r + TO_W'(1);
      end
   end

   assign timeout_hit_s = (state_r == ST_STREAM) & ~xfer_s & (stall_r == TO_W'(TIMEOUT - 1));
`else
   assign timeout_hit_s = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state: grab a requester from IDLE, drop back on release.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (pick_valid_s) begin
               state_next_s = ST_STREAM;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_STREAM: begin
            if (release_s) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_STREAM;
            end
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // FSM outputs: zero-latency pass-through of the owner's byte to the UART.
   always_comb begin
      req_ready = '0;
      wr_uart   = 1'b0;
      w_data    = '0;
      case (state_r)
         ST_STREAM: begin
            req_ready[owner_r] = ~tx_full;
            wr_uart            = xfer_s;
            w_data             = owner_data_s;
         end
         ST_IDLE: begin
            wr_uart = 1'b0;
         end
         default: begin
            wr_uart = 1'b0;
         end
      endcase
   end

   // Grant, owner, pointer, byte count and trunc pulse bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_r <= '0;
         owner_r <= '0;
         ptr_r   <= '0;
         count_r <= '0;
         busy_r  <= 1'b0;
         trunc_r <= 1'b0;
      end else begin
         trunc_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (pick_valid_s) begin
                  grant_r <= pick_onehot_s;
                  owner_r <= pick_idx_s;
                  busy_r  <= 1'b1;
                  count_r <= '0;
               end else begin
                  grant_r <= '0;
                  busy_r  <= 1'b0;
               end
            end
            ST_STREAM: begin
               if (release_s) begin
                  grant_r <= '0;
                  busy_r  <= 1'b0;
                  count_r <= '0;
                  trunc_r <= trunc_next_s;
                  ptr_r   <= (owner_r == IDX_W'(N - 1)) ? '0 : owner_r + IDX_W'(1);
               end else if (xfer_s) begin
                  count_r <= count_r + CNT_W'(1);
               end else begin
                  count_r <= count_r;
               end
            end
            default: begin
               grant_r <= '0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign grant = grant_r;
   assign busy  = busy_r;
   assign trunc = trunc_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-requester byte queues drive
// the inputs, and an integer-level model of the arbitration rules predicts
// grant/busy/trunc and the write port every cycle.
module tb_uart_tx_arbiter;

   localparam int N       = 4;
   localparam int MAX_LEN = 4;
   localparam int CNT_W   = 3;
   localparam int TIMEOUT = 8;
   localparam int DEPTH   = 4096;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   grant;
   logic           wr_uart;
   logic [7:0]     w_data;
   logic           tx_full;
   logic           busy;
   logic           trunc;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .N       (N),
      .MAX_LEN (MAX_LEN),
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .grant     (grant),
      .wr_uart   (wr_uart),
      .w_data    (w_data),
      .tx_full   (tx_full),
      .busy      (busy),
      .trunc     (trunc)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Per-requester byte queues: {last, data}
   logic [8:0] q_mem [N][DEPTH];
   int q_head [N];
   int q_tail [N];

   // Reference model state: owner index (-1 = idle), rr pointer, byte count, stall count
   int m_owner, m_ptr, m_cnt, m_stall;
   bit m_trunc;
   int n_dut_writes   = 0;
   int n_model_writes = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic push_byte(input int r, input logic [7:0] b, input bit last);
      if (q_tail[r] < DEPTH) begin
         q_mem[r][q_tail[r]] = {last, b};
         q_tail[r]++;
      end
   endtask

   task automatic add_pkt(input int r, input int len, input bit with_last);
      for (int k = 0; k < len; k++)
         push_byte(r, 8'($urandom), with_last && (k == len - 1));
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
      m_stall = 0;
      m_trunc = 1'b0;
   endtask

   task automatic release_owner(input bit tr);
      m_trunc = tr;
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_cnt   = 0;
      m_stall = 0;
   endtask

   // One cycle, entered and left at a negative clock edge.
   task automatic step(input int p_en, input int p_full, input bit refill, input bit do_rst);
      logic [N-1:0] exp_grant;
      logic [N-1:0] exp_ready;
      bit           exp_wr;
      bit           found;
      bit           lastb;
      int           g;

      exp_grant = '0;
      if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
      check_eq("grant", 32'(grant), 32'(exp_grant));
      check_eq("busy",  32'(busy),  32'(m_owner >= 0));
      check_eq("trunc", 32'(trunc), 32'(m_trunc));

      for (int i = 0; i < N; i++) begin
         if (refill && (q_head[i] == q_tail[i]) && ($urandom_range(0, 99) < 8))
            add_pkt(i, $urandom_range(1, 6), 1'b1);
         req_valid[i] = !do_rst && (q_head[i] < q_tail[i]) && ($urandom_range(0, 99) < p_en);
         if (q_head[i] < q_tail[i]) begin
            req_data[8*i +: 8] = q_mem[i][q_head[i]][7:0];
            req_last[i]        = q_mem[i][q_head[i]][8];
         end else begin
            req_data[8*i +: 8] = 8'($urandom);
            req_last[i]        = 1'($urandom);
         end
      end
      tx_full = ($urandom_range(0, 99) < p_full);
      reset   = do_rst;
      #1;

      exp_wr    = (m_owner >= 0) && req_valid[m_owner] && !tx_full;
      exp_ready = '0;
      if (m_owner >= 0) exp_ready[m_owner] = !tx_full;
      check_eq("wr_uart",   32'(wr_uart),   32'(exp_wr));
      check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
      if (exp_wr) check_eq("w_data", 32'(w_data), 32'(q_mem[m_owner][q_head[m_owner]][7:0]));
      if (wr_uart === 1'b1) n_dut_writes++;

      if (do_rst) begin
         model_reset();
      end else if (m_owner < 0) begin
         m_trunc = 1'b0;
         found   = 1'b0;
         for (int k = 0; k < N; k++) begin
            g = (m_ptr + k) % N;
            if (!found && req_valid[g]) begin
               found   = 1'b1;
               m_owner = g;
               m_cnt   = 0;
               m_stall = 0;
            end
         end
      end else begin
         m_trunc = 1'b0;
         if (exp_wr) begin
            lastb = q_mem[m_owner][q_head[m_owner]][8];
            q_head[m_owner]++;
            m_cnt++;
            m_stall = 0;
            n_model_writes++;
            if (lastb || (m_cnt == MAX_LEN)) release_owner(!lastb);
         end else begin
`ifdef UART_ARB_TIMEOUT_EN
            m_stall++;
            if (m_stall == TIMEOUT) release_owner(1'b1);
`endif
         end
      end
      @(negedge clk);
   endtask

   initial begin
      int remaining;
      reset     = 1'b1;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      tx_full   = 1'b0;
      for (int i = 0; i < N; i++) begin
         q_head[i] = 0;
         q_tail[i] = 0;
      end
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Idle after reset
      repeat (20) step(0, 0, 1'b0, 1'b0);

      // Req0: 3-byte packet 11,22,33
      push_byte(0, 8'h11, 1'b0);
      push_byte(0, 8'h22, 1'b0);
      push_byte(0, 8'h33, 1'b1);
      repeat (8) step(100, 0, 1'b0, 1'b0);

      // Pointer back to 0, then all four send 1-byte packets
      step(100, 0, 1'b0, 1'b1);
      for (int i = 0; i < N; i++) push_byte(i, 8'(8'hA0 + i), 1'b1);
      repeat (12) step(100, 0, 1'b0, 1'b0);

      // Req2 stalled by tx_full for 5 cycles mid-packet
      add_pkt(2, 5, 1'b1);
      repeat (3) step(100, 0, 1'b0, 1'b0);
      repeat (5) step(100, 100, 1'b0, 1'b0);
      repeat (8) step(100, 0, 1'b0, 1'b0);

      // Req1: 6 bytes with no last, truncated at MAX_LEN, then closing byte
      add_pkt(1, 6, 1'b0);
      push_byte(1, 8'h77, 1'b1);
      repeat (14) step(100, 0, 1'b0, 1'b0);

`ifdef UART_ARB_TIMEOUT_EN
      // Owner runs dry mid-packet: forced release after TIMEOUT stall cycles
      add_pkt(3, 2, 1'b0);
      repeat (16) step(100, 0, 1'b0, 1'b0);
`endif

      // Reset in the middle of a packet
      add_pkt(0, 6, 1'b1);
      repeat (3) step(100, 0, 1'b0, 1'b0);
      step(100, 0, 1'b0, 1'b1);
      repeat (10) step(100, 0, 1'b0, 1'b0);

      // Randomized traffic with backpressure and occasional resets
      repeat (2000) step(70, 20, 1'b1, $urandom_range(0, 499) == 0);
      repeat (800) step(30, 10, 1'b1, 1'b0);

      // Drain all queues
      remaining = 1;
      for (int c = 0; c < 600 && remaining != 0; c++) begin
         step(100, 0, 1'b0, 1'b0);
         remaining = 0;
         for (int i = 0; i < N; i++) remaining += q_tail[i] - q_head[i];
      end
      repeat (3) step(100, 0, 1'b0, 1'b0);
      check_eq("drained", 32'(remaining), 32'd0);
      check_eq("write_count", 32'(n_dut_writes), 32'(n_model_writes));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
